// File: rtl/lagarto_plic_pkg.sv
// Shared PLIC types: interrupt IDs and the per-source gateway state encoding.
package lagarto_plic_pkg;

  localparam int unsigned INTERRUPT_ID_W = 8;
  typedef logic [INTERRUPT_ID_W-1:0] interrupt_id_t;
  localparam interrupt_id_t NO_INTERRUPT_ID = '0;

  localparam int unsigned MAX_SYNC_STAGES           = 4;
  localparam int unsigned DEFAULT_MAX_PENDING_EDGES = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } gateway_state_t;

endpackage

// File: rtl/lagarto_plic_synchronizer.sv
// N-flop synchronizer for an asynchronous single-bit line; q is the last stage.
module lagarto_plic_synchronizer
  import lagarto_plic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  if ((SYNC_STAGES < 1) || (SYNC_STAGES > MAX_SYNC_STAGES)) begin : g_bad_stages
    $error("lagarto_plic_synchronizer: SYNC_STAGES out of range 1..%0d", MAX_SYNC_STAGES);
  end

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stages <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/lagarto_plic_gateway.sv
// PLIC interrupt gateway for one source: level/edge request capture, claim/complete
// handshake, and a saturating queue of edges that arrived while the source was busy.
module lagarto_plic_gateway
  import lagarto_plic_pkg::*;
#(
  parameter interrupt_id_t SOURCE_ID         = interrupt_id_t'(1),
  parameter int unsigned   SYNC_STAGES       = 2,
  parameter int unsigned   MAX_PENDING_EDGES = DEFAULT_MAX_PENDING_EDGES,
  localparam int unsigned  CNT_W             = $clog2(MAX_PENDING_EDGES + 1)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               interrupt_source_i,
  input  logic               edge_trigger_i,
  input  logic               claim_i,
  input  logic               complete_valid_i,
  input  interrupt_id_t      complete_id_i,
  output logic               source_interrupt_pending_o,
  output logic               in_service_o,
  output logic [CNT_W-1:0]   edge_count_o,
  output logic               edge_dropped_o
);

  if (SOURCE_ID == NO_INTERRUPT_ID) begin : g_bad_id
    $error("lagarto_plic_gateway: SOURCE_ID must not be NO_INTERRUPT_ID");
  end
  if ((MAX_PENDING_EDGES < 1) || (MAX_PENDING_EDGES > 255)) begin : g_bad_max
    $error("lagarto_plic_gateway: MAX_PENDING_EDGES out of range 1..255");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING_EDGES);

  logic               s;
  logic               s_d;
  logic               rise;
  logic               req;
  gateway_state_t     state, state_n;
  logic [CNT_W-1:0]   count, count_n;
  logic               drop_n;
  logic               pending, in_service, dropped;

  lagarto_plic_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk_i),
    .rstn (rstn_i),
    .d    (interrupt_source_i),
    .q    (s)
  );

  assign rise = s & ~s_d;
  assign req  = edge_trigger_i ? (rise | (count != '0)) : s;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (req) state_n = PENDING;
      PENDING:    if (claim_i) state_n = IN_SERVICE;
      IN_SERVICE: if (complete_valid_i && (complete_id_i == SOURCE_ID)) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // In IDLE a fresh edge is either bypassed (empty queue) or cancels the decrement.
  always_comb begin
    count_n = count;
    drop_n  = 1'b0;
    if (!edge_trigger_i) begin
      count_n = '0;
    end else if (state == IDLE) begin
      if ((count != '0) && !rise) count_n = count - 1'b1;
    end else if (rise) begin
      if (count == MAX_CNT) drop_n  = 1'b1;
      else                  count_n = count + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      s_d        <= 1'b0;
      count      <= '0;
      pending    <= 1'b0;
      in_service <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state      <= state_n;
      s_d        <= s;
      count      <= count_n;
      pending    <= (state_n == PENDING);
      in_service <= (state_n == IN_SERVICE);
      dropped    <= drop_n;
    end
  end

  assign source_interrupt_pending_o = pending;
  assign in_service_o               = in_service;
  assign edge_count_o               = count;
  assign edge_dropped_o             = dropped;

endmodule

// File: tb/tb_lagarto_plic_gateway.sv
// Directed bench for lagarto_plic_gateway: a default instance plus one with a 2-deep edge queue.
module tb_lagarto_plic_gateway;
  import lagarto_plic_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          src = 1'b0;
  logic          etrig = 1'b0;
  logic          claim = 1'b0;
  logic          cv = 1'b0;
  interrupt_id_t cid = '0;

  logic       pend, insvc, drop;
  logic [3:0] cnt;
  logic       pend2, insvc2, drop2;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;
  int drop_cnt = 0;

  always #5 clk = ~clk;

  lagarto_plic_gateway #(
    .SOURCE_ID (8'd3), .SYNC_STAGES (2), .MAX_PENDING_EDGES (8)
  ) dut (
    .clk_i (clk), .rstn_i (rstn), .interrupt_source_i (src), .edge_trigger_i (etrig),
    .claim_i (claim), .complete_valid_i (cv), .complete_id_i (cid),
    .source_interrupt_pending_o (pend), .in_service_o (insvc),
    .edge_count_o (cnt), .edge_dropped_o (drop)
  );

  lagarto_plic_gateway #(
    .SOURCE_ID (8'd3), .SYNC_STAGES (2), .MAX_PENDING_EDGES (2)
  ) dut2 (
    .clk_i (clk), .rstn_i (rstn), .interrupt_source_i (src), .edge_trigger_i (etrig),
    .claim_i (claim), .complete_valid_i (cv), .complete_id_i (cid),
    .source_interrupt_pending_o (pend2), .in_service_o (insvc2),
    .edge_count_o (cnt2), .edge_dropped_o (drop2)
  );

  always @(negedge clk) if (drop2 === 1'b1) drop_cnt <= drop_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; src = 1'b0; claim = 1'b0; cv = 1'b0; cid = '0;
    step(); step();
    rstn = 1'b1;
  endtask

  task automatic pulse();
    src = 1'b1; step(); step();
    src = 1'b0; step(); step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    checks++;
    if ({pend, insvc, cnt, drop} !== 7'b0) begin
      $display("FAIL reset_outputs got=%b want=0", {pend, insvc, cnt, drop}); failures++;
    end
    checks++;
    if ({pend2, insvc2, cnt2, drop2} !== 5'b0) begin
      $display("FAIL reset_outputs2 got=%b want=0", {pend2, insvc2, cnt2, drop2}); failures++;
    end
    rstn = 1'b1;
  endtask

  task automatic test_level();
    do_reset();
    etrig = 1'b0;
    src = 1'b1;
    step(); step();
    checks++;
    if (pend !== 1'b0) begin $display("FAIL lvl_latency_e1 got=%b want=0", pend); failures++; end
    step();
    checks++;
    if (pend !== 1'b1) begin $display("FAIL lvl_latency_e2 got=%b want=1", pend); failures++; end
    step(); step();
    claim = 1'b1; step(); claim = 1'b0;
    checks++;
    if ({pend, insvc} !== 2'b01) begin $display("FAIL lvl_claim got=%b want=01", {pend, insvc}); failures++; end
    cv = 1'b1; cid = 8'd4; step(); cv = 1'b0;
    checks++;
    if (insvc !== 1'b1) begin $display("FAIL lvl_wrong_id got=%b want=1", insvc); failures++; end
    claim = 1'b1; step(); claim = 1'b0;
    checks++;
    if ({pend, insvc} !== 2'b01) begin $display("FAIL lvl_claim_in_service got=%b want=01", {pend, insvc}); failures++; end
    cv = 1'b1; cid = 8'd3; step(); cv = 1'b0;
    checks++;
    if ({pend, insvc} !== 2'b00) begin $display("FAIL lvl_complete_idle got=%b want=00", {pend, insvc}); failures++; end
    step();
    checks++;
    if (pend !== 1'b1) begin $display("FAIL lvl_back_to_back got=%b want=1", pend); failures++; end
    src = 1'b0; step(); step(); step();
    checks++;
    if (pend !== 1'b1) begin $display("FAIL lvl_drop_hold got=%b want=1", pend); failures++; end
    cv = 1'b1; cid = 8'd3; step(); cv = 1'b0;
    checks++;
    if ({pend, insvc} !== 2'b10) begin $display("FAIL lvl_complete_in_pending got=%b want=10", {pend, insvc}); failures++; end
    claim = 1'b1; cv = 1'b1; step(); claim = 1'b0; cv = 1'b0;
    checks++;
    if ({pend, insvc} !== 2'b01) begin $display("FAIL lvl_claim_wins got=%b want=01", {pend, insvc}); failures++; end
    cv = 1'b1; step(); cv = 1'b0; step(); step();
    checks++;
    if ({pend, insvc, cnt} !== 6'b0) begin $display("FAIL lvl_idle_after got=%b want=0", {pend, insvc, cnt}); failures++; end
    claim = 1'b1; step(); claim = 1'b0;
    checks++;
    if ({pend, insvc} !== 2'b00) begin $display("FAIL lvl_claim_idle got=%b want=00", {pend, insvc}); failures++; end
  endtask

  task automatic test_edge_queue();
    etrig = 1'b1;
    do_reset();
    pulse();
    checks++;
    if ({pend, cnt} !== 5'b1_0000) begin $display("FAIL edg_bypass got=%b want=10000", {pend, cnt}); failures++; end
    claim = 1'b1; step(); claim = 1'b0;
    repeat (3) pulse();
    checks++;
    if ({insvc, cnt} !== 5'b1_0011) begin $display("FAIL edg_queue3 got=%b want=10011", {insvc, cnt}); failures++; end
    for (int k = 0; k < 3; k++) begin
      cv = 1'b1; cid = 8'd3; step(); cv = 1'b0;
      step();
      checks++;
      if ({pend, cnt} !== {1'b1, 4'(2 - k)}) begin
        $display("FAIL edg_round%0d got=%b want=%b", k, {pend, cnt}, {1'b1, 4'(2 - k)}); failures++;
      end
      claim = 1'b1; step(); claim = 1'b0;
      checks++;
      if (insvc !== 1'b1) begin $display("FAIL edg_round%0d_claim got=%b want=1", k, insvc); failures++; end
    end
    cv = 1'b1; step(); cv = 1'b0; step();
    checks++;
    if ({pend, insvc, cnt} !== 6'b0) begin $display("FAIL edg_drained got=%b want=0", {pend, insvc, cnt}); failures++; end
  endtask

  task automatic test_saturation();
    int d0;
    etrig = 1'b1;
    do_reset();
    d0 = drop_cnt;
    pulse();
    claim = 1'b1; step(); claim = 1'b0;
    repeat (4) pulse();
    step();
    checks++;
    if ({insvc2, cnt2} !== 3'b1_10) begin $display("FAIL sat_count got=%b want=110", {insvc2, cnt2}); failures++; end
    checks++;
    if (drop_cnt - d0 !== 2) begin $display("FAIL sat_drops got=%0d want=2", drop_cnt - d0); failures++; end
  endtask

  task automatic test_back_to_back_edge();
    etrig = 1'b1;
    do_reset();
    pulse();
    claim = 1'b1; step(); claim = 1'b0;
    repeat (2) pulse();
    src = 1'b1; step();
    cv = 1'b1; cid = 8'd3; step(); cv = 1'b0;
    checks++;
    if ({pend, insvc, cnt} !== 6'b00_0010) begin $display("FAIL sim_complete got=%b want=000010", {pend, insvc, cnt}); failures++; end
    step();
    checks++;
    if ({pend, cnt} !== 5'b1_0010) begin $display("FAIL sim_net_zero got=%b want=10010", {pend, cnt}); failures++; end
    src = 1'b0; step(); step();
    repeat (3) pulse();
    checks++;
    if (cnt !== 4'd5) begin $display("FAIL sim_count5 got=%0d want=5", cnt); failures++; end
    etrig = 1'b0; step();
    checks++;
    if ({pend, cnt} !== 5'b1_0000) begin $display("FAIL mode_switch got=%b want=10000", {pend, cnt}); failures++; end
  endtask

  task automatic test_reset_mid();
    etrig = 1'b1;
    do_reset();
    repeat (5) pulse();
    checks++;
    if ({pend, cnt} !== 5'b1_0100) begin $display("FAIL rst_setup got=%b want=10100", {pend, cnt}); failures++; end
    rstn = 1'b0; step(); rstn = 1'b1;
    checks++;
    if ({pend, insvc, cnt, drop} !== 7'b0) begin $display("FAIL rst_mid got=%b want=0", {pend, insvc, cnt, drop}); failures++; end
    repeat (5) step();
    checks++;
    if ({pend, cnt} !== 5'b0) begin $display("FAIL rst_no_spurious got=%b want=0", {pend, cnt}); failures++; end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_queue();
    test_saturation();
    test_back_to_back_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lagarto_plic_gateway.md
Name: lagarto_plic_gateway

Overview:
- Per-source PLIC interrupt gateway. Converts one raw interrupt source line (level- or edge-triggered) into a single pending request on `source_interrupt_pending_o`.
- `source_interrupt_pending_o` is the pending input of the priority-compare tree.
- Blocks further requests from the same source until the target claims it and then completes it, per the RISC-V PLIC claim/complete protocol.
- One instance per source ID (IDs 1..N); ID 0 is reserved as `NO_INTERRUPT_ID`.

Parameters:
- `SOURCE_ID`, 1, `interrupt_id_t` value of this source; must not equal `NO_INTERRUPT_ID`.
- `SYNC_STAGES`, 2, synchronizer flops on `interrupt_source_i`; legal range 1..4.
- `MAX_PENDING_EDGES`, 8, saturation limit of the edge counter; legal range 1..255.

Ports:
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset: synchronous, active-low.
- `interrupt_source_i`  in  1  raw asynchronous interrupt line from the device.
- `edge_trigger_i`  in  1  0 = level-triggered, 1 = rising-edge-triggered.
- `claim_i`  in  1  one-cycle pulse; the target claimed this source.
- `complete_valid_i`  in  1  one-cycle pulse; a completion ID was written.
- `complete_id_i`  in  `interrupt_id_t`  ID written to the complete register.
- `source_interrupt_pending_o`  out  1  request pending toward the priority tree.
- `in_service_o`  out  1  claimed, completion outstanding.
- `edge_count_o`  out  `$clog2(MAX_PENDING_EDGES+1)`  queued, not-yet-forwarded edges.
- `edge_dropped_o`  out  1  one-cycle pulse; an edge was lost at saturation.

Behaviour:
- Reset (`rstn_i`=0 at a rising edge), including mid-operation:
  - state = `IDLE`, synchronizer flops and edge-detect flop = 0, count = 0.
  - All outputs 0 from the following cycle.
- Synchronizer:
  - `s` = output of stage `SYNC_STAGES`; `s_d` = `s` registered once.
  - `edge` = `s & ~s_d` (combinational).
- Request condition `req`:
  - Level mode: `req` = `s`.
  - Edge mode: `req` = `edge | (count != 0)`.
- FSM (`gateway_state_t`):
  - `IDLE`: `req` -> `PENDING`.
  - `PENDING`: `claim_i` -> `IN_SERVICE`. Level drop and complete pulses are ignored; the pending bit stays set once forwarded.
  - `IN_SERVICE`: `complete_valid_i && complete_id_i == SOURCE_ID` -> `IDLE`. A complete with any other ID is ignored. `claim_i` is ignored.
  - `claim_i` in `IDLE` is ignored.
- Outputs: `source_interrupt_pending_o` = (state == `PENDING`); `in_service_o` = (state == `IN_SERVICE`). Both are registered state decodes.
- Latency: `source_interrupt_pending_o` rises exactly `SYNC_STAGES` rising edges after the edge that first samples `interrupt_source_i` high (`IDLE`, count 0). Same latency in both modes.
- Edge counter, edge mode only:
  - `edge` in `IDLE` with count 0 is forwarded directly (bypass); count is not incremented.
  - `IDLE` with count > 0: forward and decrement. A simultaneous `edge` in the same cycle leaves count unchanged (net zero).
  - `edge` in `PENDING` or `IN_SERVICE`: increment count.
  - At saturation (count == `MAX_PENDING_EDGES`) the edge is dropped and `edge_dropped_o` pulses 1 cycle.
  - Count never wraps.
- Level mode: count is forced to 0 every cycle. Switching `edge_trigger_i` therefore discards queued edges; FSM state is unaffected.
- Back-to-back: `complete_valid_i` in cycle t with `req` true at t+1 -> `PENDING` at t+2. There is always at least one `IDLE` cycle between completion and re-forwarding.
- Simultaneous `claim_i` and a matching complete while `PENDING`: claim wins -> `IN_SERVICE`; the complete is ignored.

Decomposition:
- `lagarto_plic_pkg`: add `gateway_state_t` enum (`IDLE`, `PENDING`, `IN_SERVICE`), `MAX_SYNC_STAGES = 4`, `DEFAULT_MAX_PENDING_EDGES = 8`. Reuse `interrupt_id_t` and `NO_INTERRUPT_ID` from the same package.
- Sub-module `lagarto_plic_synchronizer`: parameterised N-flop shift register with synchronous active-low reset, and an elaboration-time check of the legal `SYNC_STAGES` range.
- FSM and edge counter stay in the top module.

Test Plan:
- Level mode, `SYNC_STAGES`=2: source high at edge 0 -> pending=1 after edge 2. `claim_i` at edge 5 -> pending=0, `in_service_o`=1 at edge 6. `complete_id_i`=`SOURCE_ID` at edge 9 -> `IDLE`. Source still high -> pending=1 again after edge 11.
- Level mode: wrong-ID complete (`SOURCE_ID`+1) while `IN_SERVICE` -> stays `IN_SERVICE`. Source dropping while `PENDING` -> pending stays 1.
- Edge mode: 3 rising edges while `IN_SERVICE` -> `edge_count_o`=3. Complete -> 3 successive claim/complete rounds each re-assert pending; `edge_count_o` steps 2, 1, 0.
- Edge mode, `MAX_PENDING_EDGES`=2: 4 edges while `IN_SERVICE` -> count=2, two `edge_dropped_o` pulses.
- Edge arriving in the same cycle an `IDLE` decrement occurs -> count unchanged, pending=1. Switching to level mode with count=5 -> count=0 next cycle.
- `rstn_i`=0 for 1 cycle while `PENDING` with count=4 -> all outputs 0 next cycle; no spurious pending until a new source assertion.
